instr_aligner: RTL

- Sits between the instruction fetch buffer and the ID-stage decoder.
- Extracts 16-bit (RVC) and 32-bit (RVI) instructions from a stream of 32-bit fetch words.
- Handles instructions that straddle two words and jump targets at halfword offsets.
- Presents one aligned instruction per cycle through a registered valid/ready output, carrying fetch error, align error and PC.

---
 rtl/instr_aligner.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_aligner.sv
// Instruction aligner: cuts 16-bit (RVC) and 32-bit (RVI) instructions out of
// a stream of 32-bit fetch words. A leftover halfword is kept when an
// instruction straddles two words. One registered instruction per cycle
// goes to the decoder over a valid/ready output.
module instr_aligner (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_flush_i,
  input  logic        s_wvalid_i,
  input  logic [31:0] s_word_i,
  input  logic [30:0] s_waddr_i,
  input  logic [2:0]  s_werror_i,
  output logic        s_pop_o,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_instr_o,
  output logic [30:0] s_pc_o,
  output logic [2:0]  s_fetch_error_o,
  output logic        s_align_error_o
);

  // Fetch error encoding: FETCH_VALID is 0. Other codes, including the
  // incomplete-fetch code, pass through unchanged.
  localparam logic [2:0] FETCH_VALID = 3'b000;

  // EMPTY: no leftover. HALF: hw_q holds a halfword that has not been emitted.
  typedef enum logic {EMPTY, HALF} state_t;

  state_t      state_q, state_d;
  logic [15:0] hw_q, hw_d;
  logic [30:0] hw_pc_q, hw_pc_d;
  logic [2:0]  hw_err_q, hw_err_d;

  logic        adv, pop, emit;
  logic [31:0] instr_d;
  logic [30:0] pc_d;
  logic [2:0]  ferr_d;
  logic        aerr_d;
  logic [15:0] lo, hi;

  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign adv = ~s_valid_o | s_ready_i;
  assign lo  = s_word_i[15:0];
  assign hi  = s_word_i[31:16];

  // The word is consumed only if the output register can advance and no
  // flush or reset is active in this cycle.
  assign s_pop_o = pop & adv & ~s_flush_i & ~s_reset_i;

  // Next-state logic: chooses what to emit, whether to consume the word, and
  // what stays behind as the leftover halfword.
  always_comb begin
    state_d  = state_q;
    hw_d     = hw_q;
    hw_pc_d  = hw_pc_q;
    hw_err_d = hw_err_q;
    pop      = 1'b0;
    emit     = 1'b0;
    instr_d  = s_instr_o;
    pc_d     = s_pc_o;
    ferr_d   = s_fetch_error_o;
    aerr_d   = s_align_error_o;
    unique case (state_q)
      EMPTY: begin
        if (s_wvalid_i) begin
          pop    = 1'b1;
          ferr_d = s_werror_i;
          aerr_d = 1'b0;
          pc_d   = s_waddr_i;
          if (!s_waddr_i[0]) begin
            emit = 1'b1;
            if (is_rvc(lo)) begin
              instr_d  = {16'h0, lo};
              state_d  = HALF;
              hw_d     = hi;
              hw_pc_d  = s_waddr_i + 31'd1;
              hw_err_d = s_werror_i;
            end else begin
              instr_d = s_word_i;
            end
          end else if (is_rvc(hi)) begin
            emit    = 1'b1;
            instr_d = {16'h0, hi};
          end else begin
            // Entered at the upper half of the word and the upper half starts a
            // 32-bit instruction: keep it and wait for the next word.
            state_d  = HALF;
            hw_d     = hi;
            hw_pc_d  = s_waddr_i;
            hw_err_d = s_werror_i;
          end
        end
      end
      HALF: begin
        if (is_rvc(hw_q)) begin
          // A compressed leftover goes out first. The incoming word waits.
          emit    = 1'b1;
          instr_d = {16'h0, hw_q};
          pc_d    = hw_pc_q;
          ferr_d  = hw_err_q;
          aerr_d  = 1'b0;
          state_d = EMPTY;
        end else if (s_wvalid_i) begin
          pop     = 1'b1;
          emit    = 1'b1;
          instr_d = {lo, hw_q};
          pc_d    = hw_pc_q;
          if (!s_waddr_i[0]) begin
            ferr_d   = (hw_err_q != FETCH_VALID) ? hw_err_q : s_werror_i;
            aerr_d   = 1'b0;
            hw_d     = hi;
            hw_pc_d  = s_waddr_i + 31'd1;
            hw_err_d = s_werror_i;
          end else begin
            // The stream broke in the middle of a straddling instruction.
            ferr_d   = FETCH_VALID;
            aerr_d   = 1'b1;
            state_d  = EMPTY;
            hw_d     = '0;
            hw_pc_d  = '0;
            hw_err_d = FETCH_VALID;
          end
        end
      end
      default: ;
    endcase
  end

  // State and output register. Reset and flush both clear to the same state.
  // Everything holds while the decoder stalls.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i || s_flush_i) begin
      state_q         <= EMPTY;
      hw_q            <= '0;
      hw_pc_q         <= '0;
      hw_err_q        <= FETCH_VALID;
      s_valid_o       <= 1'b0;
      s_instr_o       <= '0;
      s_pc_o          <= '0;
      s_fetch_error_o <= FETCH_VALID;
      s_align_error_o <= 1'b0;
    end else if (adv) begin
      state_q         <= state_d;
      hw_q            <= hw_d;
      hw_pc_q         <= hw_pc_d;
      hw_err_q        <= hw_err_d;
      s_valid_o       <= emit;
      s_instr_o       <= instr_d;
      s_pc_o          <= pc_d;
      s_fetch_error_o <= ferr_d;
      s_align_error_o <= aerr_d;
    end
  end

endmodule
